edge_binarizer: RTL and testbench
=================================

# edge_binarizer

Downstream of the gradient magnitude stage and upstream of the output framer. The block takes the stream of unsigned magnitude samples and compares each one against a per-frame threshold to produce a 1-bit edge pixel. It tracks the column and row position of every sample and forces a configurable border of pixels to zero. It flags the last pixel of each frame and, optionally, reports the number of edge pixels in the frame.

## Interface
- MagWidth, 6, width of the unsigned magnitude input and of the threshold
- WidthOut, 318, pixels per output line
- HeightOut, 238, lines per output frame
- BorderPx, 1, pixels forced to 0 at every frame edge; must satisfy 2*BorderPx < WidthOut and 2*BorderPx < HeightOut
- CountWidth, $clog2(WidthOut*HeightOut+1), width of the edge counter

- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-low reset
- thresh_i  in  MagWidth  threshold, sampled on the first beat of each frame
- valid_i  in  1  magnitude beat valid
- ready_o  out  1  block can accept a beat
- mag_i  in  MagWidth  unsigned magnitude
- valid_o  out  1  edge pixel valid
- ready_i  in  1  downstream accepts
- edge_o  out  1  binarized pixel
- eof_o  out  1  qualifies the current valid_o beat as the last pixel of the frame
- edge_count_o  out  CountWidth  edge pixels in the last completed frame (EDGE_BIN_STATS_EN only)
- count_valid_o  out  1  one-cycle pulse when edge_count_o updates (EDGE_BIN_STATS_EN only)

## Operation
- Accept occurs when valid_i & ready_o. Emit occurs when valid_o & ready_i.
- Column counter col runs 0..WidthOut-1. Row counter row runs 0..HeightOut-1. Both advance only on accept.
  - col wraps to 0 and row increments at col == WidthOut-1.
  - Both wrap to 0 at col == WidthOut-1 and row == HeightOut-1.
- Threshold selection:
  - On an accept with col == 0 and row == 0, thresh_q <= thresh_i, and that same beat compares against thresh_i directly.
  - All other beats compare against thresh_q.
  - A change on thresh_i mid-frame has no effect until the next frame.
- Pixel rule: edge = (mag_i >= threshold). The comparison is unsigned and full width.
- Border rule: edge is forced to 0 when col < BorderPx, col >= WidthOut-BorderPx, row < BorderPx, or row >= HeightOut-BorderPx.
- eof is 1 for the beat accepted at (WidthOut-1, HeightOut-1).
- The output register holds {edge, eof}. It loads on accept and holds its value while valid_o & ~ready_i.

## Timing
- Reset values: valid_o=0, edge_o=0, eof_o=0, edge_count_o=0, count_valid_o=0, col=0, row=0, thresh_q=0, accumulator=0.
- Latency is one cycle from accept to valid_o.
- ready_o = ~valid_o | ready_i. This gives full throughput of one beat per cycle, with a combinational path from ready_i to ready_o only.
- An accept and an emit in the same cycle replace the output register contents; no bubble is inserted.
- valid_o must not drop and {edge_o, eof_o} must not change while valid_o & ~ready_i.
- Reset asserted mid-frame: all state clears immediately, and the next accepted beat is treated as pixel (0,0).
- Stats timing: count_valid_o pulses in the cycle after the eof beat is accepted. It is not gated by ready_i.

## Configuration
- EDGE_BIN_STATS_EN defined:
  - An accumulator adds edge on every accept.
  - On the eof accept, edge_count_o <= accumulator + edge, the accumulator clears to 0, and count_valid_o pulses for one cycle.
- EDGE_BIN_STATS_EN undefined:
  - The accumulator is not built.
  - edge_count_o is tied to 0 and count_valid_o is tied to 0.
  - The pixel stream behaviour is identical in both builds.

## Test plan
- Reset and idle: hold rst_i=0, then release with valid_i=0. Required: valid_o=0, eof_o=0, ready_o=1, and no count_valid_o pulse.
- Threshold compare: WidthOut=6, HeightOut=5, BorderPx=1, thresh_i=4. Stream mag=4 at interior pixel (2,2) and mag=3 at (3,2). Required: edge_o=1 and 0 respectively, each one cycle after accept.
- Border suppression: same parameters, all mag=63. Required: only the 4x3 interior gives edge_o=1 (12 ones per frame). eof_o=1 only on the 30th beat.
- Backpressure: hold ready_i=0 for 5 cycles with valid_o=1. Required: ready_o=0 and the output stable throughout. Then ready_i=1 with valid_i=1 continuously gives one beat per cycle with no loss or duplication.
- Threshold latch: change thresh_i from 4 to 60 mid-frame. Required: the current frame still uses 4, and the next frame uses 60.
- Stats and mid-frame reset (EDGE_BIN_STATS_EN): an all-63 frame gives edge_count_o=12 with a single count_valid_o pulse. Asserting rst_i after beat 10 and resending the full frame gives edge_count_o=12 again, with eof_o on beat 30 after reset.

Source files
------------

// File: rtl/edge_binarizer.sv
// edge_binarizer: thresholds unsigned gradient magnitudes into 1-bit edge pixels,
// tracks (col,row) per accepted beat, zeroes a BorderPx-wide frame border and
// flags the last pixel of each frame. One register stage, full throughput.
// Ports: clk_i/rst_i (async active-low); valid_i/ready_o/mag_i/thresh_i in;
// valid_o/ready_i/edge_o/eof_o out; edge_count_o/count_valid_o statistics.
// Optional feature: define EDGE_BIN_STATS_EN to build the per-frame edge counter;
// without it edge_count_o and count_valid_o are tied to 0.
module edge_binarizer #(
   parameter int MagWidth   = 6,
   parameter int WidthOut   = 318,
   parameter int HeightOut  = 238,
   parameter int BorderPx   = 1,
   parameter int CountWidth = $clog2(WidthOut*HeightOut+1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [MagWidth-1:0]   thresh_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [MagWidth-1:0]   mag_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  edge_o,
   output logic                  eof_o,
   output logic [CountWidth-1:0] edge_count_o,
   output logic                  count_valid_o
);

   localparam int ColW = (WidthOut  > 1) ? $clog2(WidthOut)  : 1;
   localparam int RowW = (HeightOut > 1) ? $clog2(HeightOut) : 1;

   localparam logic [ColW-1:0] ColLast = ColW'(WidthOut - 1);
   localparam logic [ColW-1:0] ColLo   = ColW'(BorderPx);
   localparam logic [ColW-1:0] ColHi   = ColW'(WidthOut - BorderPx);
   localparam logic [RowW-1:0] RowLast = RowW'(HeightOut - 1);
   localparam logic [RowW-1:0] RowLo   = RowW'(BorderPx);
   localparam logic [RowW-1:0] RowHi   = RowW'(HeightOut - BorderPx);

   logic [ColW-1:0]     col;
   logic [RowW-1:0]     row;
   logic [MagWidth-1:0] thresh_q;
   logic [MagWidth-1:0] thresh_sel;
   logic                accept;
   logic                first_px;
   logic                at_eol;
   logic                at_eof;
   logic                interior;
   logic                pix_edge;
   logic                valid_q;
   logic                edge_q;
   logic                eof_q;

   // The output stage can take a new beat whenever it is empty or being drained.
   assign ready_o = ~valid_q | ready_i;
   assign accept  = valid_i & ready_o;

   // First pixel of a frame compares against the live threshold so the frame
   // uses one consistent value from its very first beat.
   assign first_px   = (col == '0) && (row == '0);
   assign thresh_sel = first_px ? thresh_i : thresh_q;

   assign at_eol   = (col == ColLast);
   assign at_eof   = at_eol && (row == RowLast);
   assign interior = (col >= ColLo) && (col < ColHi) && (row >= RowLo) && (row < RowHi);
   assign pix_edge = interior && (mag_i >= thresh_sel);

   // Position counters and frame threshold latch.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         col      <= '0;
         row      <= '0;
         thresh_q <= '0;
      end else if (accept) begin
         if (first_px) begin
            thresh_q <= thresh_i;
         end
         if (at_eol) begin
            col <= '0;
            row <= (row == RowLast) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Output register: loads on accept, holds while stalled, empties on drain.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         edge_q  <= 1'b0;
         eof_q   <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         edge_q  <= pix_edge;
         eof_q   <= at_eof;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign edge_o  = edge_q;
   assign eof_o   = eof_q;

`ifdef EDGE_BIN_STATS_EN
   logic [CountWidth-1:0] acc;
   logic [CountWidth-1:0] count_q;
   logic                  count_vld_q;

   // The eof beat's own edge is folded in directly so the published count
   // covers the complete frame; the pulse is independent of output backpressure.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc         <= '0;
         count_q     <= '0;
         count_vld_q <= 1'b0;
      end else begin
         count_vld_q <= accept & at_eof;
         if (accept) begin
            if (at_eof) begin
               count_q <= acc + CountWidth'(pix_edge);
               acc     <= '0;
            end else begin
               acc <= acc + CountWidth'(pix_edge);
            end
         end
      end
   end

   assign edge_count_o  = count_q;
   assign count_valid_o = count_vld_q;
`else
   assign edge_count_o  = '0;
   assign count_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_edge_binarizer.sv
module tb_edge_binarizer;
   localparam int MW = 6;
   localparam int W  = 6;
   localparam int H  = 5;
   localparam int B  = 1;
   localparam int CW = $clog2(W*H+1);

   logic          clk_i    = 1'b0;
   logic          rst_i    = 1'b0;
   logic [MW-1:0] thresh_i = '0;
   logic          valid_i  = 1'b0;
   logic          ready_o;
   logic [MW-1:0] mag_i    = '0;
   logic          valid_o;
   logic          ready_i  = 1'b1;
   logic          edge_o;
   logic          eof_o;
   logic [CW-1:0] edge_count_o;
   logic          count_valid_o;

   edge_binarizer #(
      .MagWidth(MW), .WidthOut(W), .HeightOut(H), .BorderPx(B)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .thresh_i(thresh_i), .valid_i(valid_i),
      .ready_o(ready_o), .mag_i(mag_i), .valid_o(valid_o), .ready_i(ready_i),
      .edge_o(edge_o), .eof_o(eof_o), .edge_count_o(edge_count_o),
      .count_valid_o(count_valid_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [MW-1:0] mag;
      logic [MW-1:0] thr;
      logic          e;
      logic          eof;
   } vec_t;
   vec_t tab[30];

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [1:0] sb[$];
   int         mcol, mrow, macc, exp_count;
   logic [MW-1:0] mthq;
   bit         pend;
   bit         use_tab = 0;
   logic [1:0] tab_exp;
   bit         stalled_prev;
   logic [1:0] prev_out;
   bit         last_acc;
   bit         rand_rdy = 0;
   int         beat_no, frame_ones, last_ones, eof_beat;

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      mcol = 0; mrow = 0; mthq = '0; macc = 0; exp_count = 0; pend = 0;
      sb.delete();
      stalled_prev = 0; prev_out = '0;
      beat_no = 0; frame_ones = 0;
   endtask

   task automatic frame_start();
      eof_beat  = 0;
      last_ones = -1;
   endtask

   // One cycle: sample 1 time unit after the falling edge, predict what the
   // next rising edge does, then wait for the following falling edge.
   task automatic tick();
      logic a, e, inner, ee, eo;
      logic [1:0] want, got;
      logic [MW-1:0] thr;
      #1;
      if (stalled_prev)
         check(valid_o === 1'b1 && {edge_o, eof_o} === prev_out, "hold_stable",
               int'({valid_o, edge_o, eof_o}), int'({1'b1, prev_out}));
      if (valid_o && !ready_i)
         check(ready_o === 1'b0, "ready_low", int'(ready_o), 0);
      else if (!valid_o)
         check(ready_o === 1'b1, "ready_idle", int'(ready_o), 1);
`ifdef EDGE_BIN_STATS_EN
      check(count_valid_o === pend, "count_valid", int'(count_valid_o), int'(pend));
      if (pend)
         check(edge_count_o === CW'(exp_count), "edge_count", int'(edge_count_o), exp_count);
`else
      check(count_valid_o === 1'b0 && edge_count_o === '0, "stats_off",
            int'(count_valid_o) + int'(edge_count_o), 0);
`endif
      pend = 0;
      a = valid_i & ready_o;
      e = valid_o & ready_i;
      if (e) begin
         if (sb.size() == 0) begin
            check(1'b0, "unexpected_beat", int'({edge_o, eof_o}), -1);
         end else begin
            want = sb.pop_front();
            got  = {edge_o, eof_o};
            check(got === want, "pixel_edge_eof", int'(got), int'(want));
            beat_no++;
            frame_ones += int'(edge_o);
            if (eof_o) begin
               eof_beat   = beat_no;
               last_ones  = frame_ones;
               beat_no    = 0;
               frame_ones = 0;
            end
         end
      end
      if (a) begin
         thr = (mcol == 0 && mrow == 0) ? thresh_i : mthq;
         if (mcol == 0 && mrow == 0) mthq = thresh_i;
         inner = (mcol >= B) && (mcol < W-B) && (mrow >= B) && (mrow < H-B);
         ee    = inner && (mag_i >= thr);
         eo    = (mcol == W-1) && (mrow == H-1);
         want  = use_tab ? tab_exp : {ee, eo};
         sb.push_back(want);
         if (eo) begin
            exp_count = macc + int'(want[1]);
            macc = 0;
            pend = 1;
         end else begin
            macc += int'(want[1]);
         end
         if (mcol == W-1) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
         end else begin
            mcol++;
         end
      end
      last_acc     = a;
      stalled_prev = valid_o & ~ready_i;
      prev_out     = {edge_o, eof_o};
      @(negedge clk_i);
   endtask

   task automatic send(input logic [MW-1:0] m, input logic [MW-1:0] t);
      int n = 0;
      mag_i = m; thresh_i = t; valid_i = 1'b1;
      do begin
         if (rand_rdy) ready_i = ($urandom_range(0, 1) == 1);
         tick();
         n++;
      end while (!last_acc && n < 200);
      if (!last_acc) check(1'b0, "accept_timeout", n, 200);
   endtask

   task automatic drain(input int n);
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst_i   = 1'b0;
      valid_i = 1'b0;
      #2;
      check(valid_o === 1'b0 && eof_o === 1'b0 && edge_o === 1'b0, "midreset_clear",
            int'({valid_o, edge_o, eof_o}), 0);
      check(count_valid_o === 1'b0, "midreset_cvalid", int'(count_valid_o), 0);
      #1;
      rst_i = 1'b1;
      model_reset();
      @(negedge clk_i);
   endtask

   initial begin
      // Threshold-compare frame: threshold 4 latched on beat 0, later beats
      // present 60 on thresh_i which must be ignored for this frame.
      for (int i = 0; i < 30; i++) tab[i] = '{mag: 6'd0, thr: 6'd60, e: 1'b0, eof: 1'b0};
      tab[0]  = '{mag: 6'd63, thr: 6'd4,  e: 1'b0, eof: 1'b0};  // (0,0) border
      tab[7]  = '{mag: 6'd5,  thr: 6'd60, e: 1'b1, eof: 1'b0};  // (1,1)
      tab[10] = '{mag: 6'd59, thr: 6'd60, e: 1'b1, eof: 1'b0};  // (4,1) still vs 4
      tab[14] = '{mag: 6'd4,  thr: 6'd60, e: 1'b1, eof: 1'b0};  // (2,2) equal
      tab[15] = '{mag: 6'd3,  thr: 6'd60, e: 1'b0, eof: 1'b0};  // (3,2) below
      tab[19] = '{mag: 6'd4,  thr: 6'd60, e: 1'b1, eof: 1'b0};  // (1,3)
      tab[22] = '{mag: 6'd63, thr: 6'd60, e: 1'b1, eof: 1'b0};  // (4,3)
      tab[23] = '{mag: 6'd63, thr: 6'd60, e: 1'b0, eof: 1'b0};  // (5,3) right border
      tab[26] = '{mag: 6'd63, thr: 6'd60, e: 1'b0, eof: 1'b0};  // (2,4) bottom border
      tab[29] = '{mag: 6'd63, thr: 6'd60, e: 1'b0, eof: 1'b1};  // (5,4) last pixel

      model_reset();
      frame_start();

      // Reset and idle
      repeat (3) @(negedge clk_i);
      check(valid_o === 1'b0, "reset_valid", int'(valid_o), 0);
      check(eof_o === 1'b0 && edge_o === 1'b0, "reset_out", int'({edge_o, eof_o}), 0);
      check(edge_count_o === '0 && count_valid_o === 1'b0, "reset_stats",
            int'(edge_count_o) + int'(count_valid_o), 0);
      rst_i = 1'b1;
      repeat (4) tick();

      // Table-driven threshold frame
      frame_start();
      use_tab = 1;
      for (int i = 0; i < 30; i++) begin
         tab_exp = {tab[i].e, tab[i].eof};
         send(tab[i].mag, tab[i].thr);
      end
      use_tab = 0;
      drain(2);
      check(eof_beat == 30, "table_eof_pos", eof_beat, 30);
      check(last_ones == 5, "table_ones", last_ones, 5);

      // Border suppression: all-63 frame
      frame_start();
      for (int i = 0; i < 30; i++) send(6'd63, 6'd4);
      drain(2);
      check(last_ones == 12, "border_ones", last_ones, 12);
      check(eof_beat == 30, "border_eof_pos", eof_beat, 30);
`ifdef EDGE_BIN_STATS_EN
      check(edge_count_o == CW'(12), "border_count", int'(edge_count_o), 12);
`endif

      // Backpressure: 5-cycle stall with a beat waiting, then full rate
      frame_start();
      for (int i = 0; i < 30; i++) begin
         if (i == 8) begin
            ready_i = 1'b0;
            valid_i = 1'b1;
            mag_i   = 6'd63;
            repeat (5) begin
               tick();
               check(valid_o === 1'b1 && ready_o === 1'b0, "bp_stall",
                     int'({valid_o, ready_o}), 2);
            end
            ready_i = 1'b1;
         end
         send((i % 3 == 0) ? 6'd0 : 6'd63, 6'd4);
      end
      drain(2);
      check(eof_beat == 30, "bp_eof_pos", eof_beat, 30);
      check(last_ones == 9, "bp_ones", last_ones, 9);

      // Threshold latch: mid-frame change to 60 applies only from next frame
      frame_start();
      for (int i = 0; i < 30; i++) send(6'd30, (i < 10) ? 6'd4 : 6'd60);
      drain(2);
      check(last_ones == 12, "latch_cur_frame", last_ones, 12);
      frame_start();
      for (int i = 0; i < 30; i++) send((i % 2 == 1) ? 6'd61 : 6'd59, 6'd60);
      drain(2);
      check(last_ones == 6, "latch_next_frame", last_ones, 6);

      // Random data, gaps and backpressure over two frames
      rand_rdy = 1;
      frame_start();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            valid_i = 1'b0;
            ready_i = ($urandom_range(0, 1) == 1);
            tick();
         end
         send(MW'($urandom_range(0, 63)), MW'($urandom_range(0, 63)));
      end
      rand_rdy = 0;
      drain(3);
      check(eof_beat == 30, "rand_eof_pos", eof_beat, 30);

      // Mid-frame reset after 10 beats, then a complete frame
      for (int i = 0; i < 10; i++) send(6'd63, 6'd4);
      do_reset();
      frame_start();
      for (int i = 0; i < 30; i++) send(6'd63, 6'd4);
      drain(2);
      check(eof_beat == 30, "rst_eof_pos", eof_beat, 30);
      check(last_ones == 12, "rst_ones", last_ones, 12);
`ifdef EDGE_BIN_STATS_EN
      check(edge_count_o == CW'(12), "rst_count", int'(edge_count_o), 12);
`endif

      check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
